mux_2to1: RTL and testbench



---
 rtl/mux_pkg.sv | 11 +
 rtl/mux_2to1_chk.sv | 28 ++
 rtl/mux_2to1_comb.sv | 23 ++
 rtl/mux_2to1.sv | 68 ++++++
 tb/tb_mux_2to1.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// Shared constants for the registered 2:1 word multiplexer.
package mux_pkg;

  // Default operand width used when the top is instantiated without overrides.
  localparam int DEFAULT_MUX_WIDTH = 4;

  // Select encodings: which operand reaches the output.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux_pkg

// File: rtl/mux_2to1_chk.sv
// Simulation checks for the multiplexer: sel must be known whenever a sample
// is taken, and both select values should be exercised.
module mux_2to1_chk
  import mux_pkg::*;
(
  input logic clk,
  input logic rst,
  input logic sel,
  input logic in_valid
);

  // Flag an unknown select on any cycle where the inputs are being sampled.
  always @(posedge clk) begin
    if (!rst && in_valid) begin
      assert (!$isunknown(sel))
        else $error("mux_2to1_chk: sel is X/Z while in_valid=1");
    end else begin
      // Not sampling this cycle: sel is don't-care.
    end
  end

  // Coverage: operand a selected on a valid cycle.
  cover property (@(posedge clk) !rst && in_valid && (sel == SEL_A));

  // Coverage: operand b selected on a valid cycle.
  cover property (@(posedge clk) !rst && in_valid && (sel == SEL_B));

endmodule : mux_2to1_chk

// File: rtl/mux_2to1_comb.sv
// Purely combinational WIDTH-bit 2:1 selector; every bit is routed unchanged.
module mux_2to1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_MUX_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // Route operand a or b to y according to the select encoding.
  always_comb begin
    y = {WIDTH{1'b0}};
    case (sel)
      SEL_A:   y = a;
      SEL_B:   y = b;
      default: y = {WIDTH{1'b0}};
    endcase
  end

endmodule : mux_2to1_comb

// File: rtl/mux_2to1.sv
// Registered 2:1 word multiplexer. The selected operand and a valid flag are
// flopped together, so y changes only on clock edges and holds when the
// upstream stalls (in_valid=0). Latency is one cycle, throughput one per cycle.
module mux_2to1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_MUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             in_valid,
  output logic [WIDTH-1:0] y,
  output logic             out_valid
);

  logic [WIDTH-1:0] sel_word_s;
  logic [WIDTH-1:0] y_d;
  logic [WIDTH-1:0] y_q;
  logic             valid_d;
  logic             valid_q;

  mux_2to1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a   (a),
    .b   (b),
    .sel (sel),
    .y   (sel_word_s)
  );

  mux_2to1_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .in_valid (in_valid)
  );

  // Next state: capture the selected word on a valid cycle, otherwise hold y.
  always_comb begin
    y_d     = y_q;
    valid_d = 1'b0;
    if (in_valid) begin
      y_d     = sel_word_s;
      valid_d = 1'b1;
    end else begin
      y_d     = y_q;
      valid_d = 1'b0;
    end
  end

  // Output registers; reset wins over any sample presented on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q     <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign y         = y_q;
  assign out_valid = valid_q;

endmodule : mux_2to1

// File: tb/tb_mux_2to1.sv
// Directed, table-driven bench for mux_2to1 (WIDTH=4) plus a short
// hand-written sequence on a WIDTH=16 instance.
module tb_mux_2to1;

  typedef struct {
    logic       rst;
    logic       in_valid;
    logic       sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_y;
    logic       exp_valid;
    string      name;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        sel;
  logic        in_valid;
  logic [3:0]  y;
  logic        out_valid;

  logic        rst16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        sel16;
  logic        in_valid16;
  logic [15:0] y16;
  logic        out_valid16;

  int n_vec;
  int n_err;
  vec_t vecs[$];

  mux_2to1 #(.WIDTH(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid)
  );

  mux_2to1 #(.WIDTH(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst16),
    .a         (a16),
    .b         (b16),
    .sel       (sel16),
    .in_valid  (in_valid16),
    .y         (y16),
    .out_valid (out_valid16)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic r, input logic iv, input logic s,
                              input logic [3:0] va, input logic [3:0] vb,
                              input logic [3:0] ey, input logic ev,
                              input string nm);
    vec_t v;
    v.rst = r; v.in_valid = iv; v.sel = s; v.a = va; v.b = vb;
    v.exp_y = ey; v.exp_valid = ev; v.name = nm;
    return v;
  endfunction

  task automatic check4(input string nm, input logic [3:0] ey, input logic ev);
    n_vec++;
    if (y !== ey || out_valid !== ev) begin
      n_err++;
      $display("FAIL %s: got y=%h out_valid=%b, expected y=%h out_valid=%b",
               nm, y, out_valid, ey, ev);
    end
  endtask

  task automatic check16(input string nm, input logic [15:0] ey, input logic ev);
    n_vec++;
    if (y16 !== ey || out_valid16 !== ev) begin
      n_err++;
      $display("FAIL %s: got y=%h out_valid=%b, expected y=%h out_valid=%b",
               nm, y16, out_valid16, ey, ev);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Each entry: inputs presented before an edge, outputs expected after it.
    // Reset held 2 cycles with a valid sample present, then released.
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'h4, 4'h1, 4'h0, 1'b0, "reset_c0"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'h4, 4'h1, 4'h0, 1'b0, "reset_c1"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h4, 4'h1, 4'h1, 1'b1, "reset_release"));
    // Toggle: sel 0,1,0,1,0 back to back.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h4, 4'h1, 4'h4, 1'b1, "toggle0"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h4, 4'h1, 4'h1, 1'b1, "toggle1"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h4, 4'h1, 4'h4, 1'b1, "toggle2"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h4, 4'h1, 4'h1, 1'b1, "toggle3"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h4, 4'h1, 4'h4, 1'b1, "toggle4"));
    // Hold: load A, then stall for 3 cycles while inputs change.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hA, 4'h1, 4'hA, 1'b1, "hold_load"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h3, 4'hC, 4'hA, 1'b0, "hold0"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h3, 4'hC, 4'hA, 1'b0, "hold1"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, 4'h3, 4'hC, 4'hA, 1'b0, "hold2"));
    // Full width: every bit toggles.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, "fw_F0_a"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1, "fw_F0_b"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'hF, 4'h0, 4'hF, 1'b1, "fw_F0_c"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h5, 4'hA, 4'h5, 1'b1, "fw_5A_a"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h5, 4'hA, 4'hA, 1'b1, "fw_5A_b"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h5, 4'hA, 4'h5, 1'b1, "fw_5A_c"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h5, 4'hA, 4'hA, 1'b1, "fw_5A_d"));
    // Equal operands: sel is irrelevant.
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, 4'h7, 4'h7, 4'h7, 1'b1, "equal_s0"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h7, 4'h7, 4'h7, 1'b1, "equal_s1"));
    // Mid-stream reset while streaming b=9.
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h2, 4'h9, 4'h9, 1'b1, "mid_pre0"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h2, 4'h6, 4'h6, 1'b1, "mid_pre1"));
    vecs.push_back(mk(1'b1, 1'b1, 1'b1, 4'h2, 4'h9, 4'h0, 1'b0, "mid_rst"));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 4'h2, 4'h9, 4'h9, 1'b1, "mid_resume"));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 4'hE, 4'hD, 4'h9, 1'b0, "mid_stall"));

    rst = 1'b1; a = 4'h0; b = 4'h0; sel = 1'b0; in_valid = 1'b0;
    rst16 = 1'b1; a16 = 16'h0000; b16 = 16'h0000; sel16 = 1'b0; in_valid16 = 1'b0;

    // Table-driven WIDTH=4 run: drive on the falling edge, sample 1 after rising.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; in_valid = vecs[i].in_valid; sel = vecs[i].sel;
      a = vecs[i].a; b = vecs[i].b;
      @(posedge clk);
      #1;
      check4(vecs[i].name, vecs[i].exp_y, vecs[i].exp_valid);
    end

    // WIDTH=16 sequence: reset, sel=0, sel=1, stall.
    @(negedge clk);
    rst16 = 1'b1; a16 = 16'h1234; b16 = 16'hBEEF; sel16 = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1;
    check16("w16_reset", 16'h0000, 1'b0);
    @(negedge clk);
    rst16 = 1'b0; sel16 = 1'b0;
    @(posedge clk); #1;
    check16("w16_sel0", 16'h1234, 1'b1);
    @(negedge clk);
    sel16 = 1'b1;
    @(posedge clk); #1;
    check16("w16_sel1", 16'hBEEF, 1'b1);
    @(negedge clk);
    in_valid16 = 1'b0; a16 = 16'h5555; b16 = 16'hAAAA; sel16 = 1'b0;
    @(posedge clk); #1;
    check16("w16_stall", 16'hBEEF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mux_2to1
